// File: rtl/draw_bounding_box_pkg.sv
// Shared constants and state encoding for the bounding-box drawer.
package draw_bounding_box_pkg;

  localparam int xSz    = 6;
  localparam int ySz    = 6;
  localparam int addrSz = 12;
  localparam int colSz  = 3;
  localparam int X_RES  = 60;
  localparam int Y_RES  = 60;

  localparam logic [colSz-1:0] BOX_COLOUR = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    TOP,
    BOTTOM,
    LEFT,
    RIGHT,
    DONE
  } state_t;

endpackage

// File: rtl/draw_bounding_box_if.sv
// Edge-search results in, frame-RAM write port and status out.
interface draw_bounding_box_if;
  import draw_bounding_box_pkg::*;

  logic              TopandBottomFound;
  logic [ySz-1:0]    mostTop;
  logic [ySz-1:0]    mostBottom;
  logic [xSz-1:0]    mostLeft;
  logic              leftFound;
  logic [xSz-1:0]    mostRight;
  logic              rightFound;
  logic              wren;
  logic [addrSz-1:0] address;
  logic [colSz-1:0]  data;
  logic              busy;
  logic              boxDone;
  logic              boxErr;

  modport master (
    output TopandBottomFound, mostTop, mostBottom, mostLeft, leftFound,
           mostRight, rightFound,
    input  wren, address, data, busy, boxDone, boxErr
  );

  modport slave (
    input  TopandBottomFound, mostTop, mostBottom, mostLeft, leftFound,
           mostRight, rightFound,
    output wren, address, data, busy, boxDone, boxErr
  );

endinterface

// File: rtl/draw_bounding_box_address_translator.sv
// Maps a pixel coordinate to its linear frame-RAM address (y*X_RES + x).
module draw_bounding_box_address_translator
  import draw_bounding_box_pkg::*;
(
  input  logic [xSz-1:0]    x,
  input  logic [ySz-1:0]    y,
  output logic [addrSz-1:0] address
);

  always_comb begin
    address = addrSz'(y) * addrSz'(X_RES) + addrSz'(x);
  end

endmodule

// File: rtl/draw_bounding_box.sv
// Latches left/right edge results and writes the rectangle perimeter into
// the frame RAM one pixel per cycle.
module draw_bounding_box
  import draw_bounding_box_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  draw_bounding_box_if.slave bus
);

  localparam logic [xSz-1:0] X_MAX = xSz'(X_RES - 1);
  localparam logic [ySz-1:0] Y_MAX = ySz'(Y_RES - 1);

  state_t state, state_next;

  logic           l_valid, r_valid, err;
  logic [xSz-1:0] left_q, right_q, x;
  logic [ySz-1:0] top_q, bottom_q, y;
  logic [addrSz-1:0] pix_addr;
  logic bad_box, tall_box, x_last, y_last, writing;

  assign bad_box  = (left_q > right_q) || (top_q > bottom_q) ||
                    (left_q > X_MAX) || (right_q > X_MAX) ||
                    (top_q > Y_MAX) || (bottom_q > Y_MAX);
  // At least one row strictly between top and bottom, so the sides have pixels.
  assign tall_box = {1'b0, bottom_q} > ({1'b0, top_q} + (ySz+1)'(1));
  assign x_last   = (x == right_q);
  assign y_last   = (y == bottom_q - ySz'(1));

  draw_bounding_box_address_translator u_xlate (
    .x       (x),
    .y       (y),
    .address (pix_addr)
  );

  always_ff @(posedge clk) begin
    if (reset || bus.TopandBottomFound || state == DONE) begin
      l_valid <= 1'b0;
      r_valid <= 1'b0;
      if (reset) begin
        left_q   <= '0;
        right_q  <= '0;
        top_q    <= '0;
        bottom_q <= '0;
      end
    end else if (state == IDLE) begin
      if (bus.leftFound) begin
        l_valid <= 1'b1;
        left_q  <= bus.mostLeft;
      end
      if (bus.rightFound) begin
        r_valid <= 1'b1;
        right_q <= bus.mostRight;
      end
      if (bus.leftFound || bus.rightFound) begin
        top_q    <= bus.mostTop;
        bottom_q <= bus.mostBottom;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.TopandBottomFound) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:   if (l_valid && r_valid) state_next = CHECK;
        CHECK:  state_next = bad_box ? DONE : TOP;
        TOP:    if (x_last) state_next = (bottom_q != top_q) ? BOTTOM : DONE;
        BOTTOM: if (x_last) state_next = tall_box ? LEFT : DONE;
        LEFT:   if (y_last) state_next = (right_q != left_q) ? RIGHT : DONE;
        RIGHT:  if (y_last) state_next = DONE;
        DONE:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Each edge section preloads the start coordinate of the section that follows.
  always_ff @(posedge clk) begin
    if (reset) begin
      x   <= '0;
      y   <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        CHECK: begin
          x   <= left_q;
          y   <= top_q;
          err <= bad_box;
        end
        TOP: begin
          if (x_last) begin
            x <= left_q;
            y <= bottom_q;
          end else begin
            x <= x + xSz'(1);
          end
        end
        BOTTOM: begin
          if (x_last) begin
            x <= left_q;
            y <= top_q + ySz'(1);
          end else begin
            x <= x + xSz'(1);
          end
        end
        LEFT: begin
          if (y_last) begin
            x <= right_q;
            y <= top_q + ySz'(1);
          end else begin
            y <= y + ySz'(1);
          end
        end
        RIGHT:   if (!y_last) y <= y + ySz'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    writing     = (state == TOP) || (state == BOTTOM) ||
                  (state == LEFT) || (state == RIGHT);
    bus.wren    = writing;
    bus.address = writing ? pix_addr : '0;
    bus.data    = writing ? BOX_COLOUR : '0;
    bus.busy    = (state != IDLE);
    bus.boxDone = (state == DONE);
    bus.boxErr  = (state == DONE) && err;
  end

endmodule

// File: tb/tb_draw_bounding_box.sv
// Directed and randomized checks of the perimeter writes against a
// coordinate-list model of the expected box.
module tb_draw_bounding_box;
  import draw_bounding_box_pkg::*;

  logic clk = 1'b0;
  logic reset;

  draw_bounding_box_if bus();

  draw_bounding_box dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int   got_addr[$];
  int   got_idx[$];
  int   got_data[$];
  int   n_done;
  int   done_idx;
  int   done_err;
  int   exp_addr[$];
  int   exp_err;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected write sequence: top row, bottom row, left side, right side.
  task automatic model(input int l, input int r, input int t, input int b);
    exp_addr.delete();
    exp_err = 0;
    if (l > r || t > b || l > 59 || r > 59 || t > 59 || b > 59) begin
      exp_err = 1;
      return;
    end
    for (int xx = l; xx <= r; xx++) exp_addr.push_back(t * 60 + xx);
    if (b != t)
      for (int xx = l; xx <= r; xx++) exp_addr.push_back(b * 60 + xx);
    for (int yy = t + 1; yy < b; yy++) exp_addr.push_back(yy * 60 + l);
    if (r != l)
      for (int yy = t + 1; yy < b; yy++) exp_addr.push_back(yy * 60 + r);
  endtask

  task automatic pulse(input logic lf, input logic rf,
                       input int l, input int r, input int t, input int b);
    bus.leftFound  = lf;
    bus.rightFound = rf;
    bus.mostLeft   = 6'(l);
    bus.mostRight  = 6'(r);
    bus.mostTop    = 6'(t);
    bus.mostBottom = 6'(b);
    @(posedge clk); #1;
    bus.leftFound  = 1'b0;
    bus.rightFound = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Cycle 0 is the cycle right after the later found pulse.
  task automatic collect(input int budget, input int inj_idx, input int inj_r);
    got_addr.delete();
    got_idx.delete();
    got_data.delete();
    n_done   = 0;
    done_idx = -1;
    done_err = -1;
    for (int c = 0; c < budget; c++) begin
      if (bus.wren) begin
        got_addr.push_back(int'(bus.address));
        got_idx.push_back(c);
        got_data.push_back(int'(bus.data));
      end
      if (bus.boxDone) begin
        n_done++;
        if (done_idx < 0) begin
          done_idx = c;
          done_err = int'(bus.boxErr);
        end
      end
      if (c == inj_idx) begin
        bus.rightFound = 1'b1;
        bus.mostRight  = 6'(inj_r);
      end else begin
        bus.rightFound = 1'b0;
      end
      tick();
    end
    bus.rightFound = 1'b0;
  endtask

  task automatic verify(input string tag);
    check({tag, " writes"}, got_addr.size(), exp_addr.size());
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      check({tag, " addr"}, got_addr[k], exp_addr[k]);
      check({tag, " cycle"}, got_idx[k], 2 + k);
      check({tag, " data"}, got_data[k], 4);
    end
    check({tag, " done_count"}, n_done, 1);
    check({tag, " done_cycle"}, done_idx, 2 + exp_addr.size());
    check({tag, " err"}, done_err, exp_err);
  endtask

  task automatic run_box(input string tag, input int l, input int r,
                         input int t, input int b);
    model(l, r, t, b);
    pulse(1'b1, 1'b1, l, r, t, b);
    collect(exp_addr.size() + 8, -1, 0);
    verify(tag);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " wren"},    int'(bus.wren), 0);
    check({tag, " address"}, int'(bus.address), 0);
    check({tag, " data"},    int'(bus.data), 0);
    check({tag, " busy"},    int'(bus.busy), 0);
    check({tag, " boxDone"}, int'(bus.boxDone), 0);
    check({tag, " boxErr"},  int'(bus.boxErr), 0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      if (bus.wren || bus.boxDone) seen++;
      tick();
    end
    check({tag, " quiet"}, seen, 0);
  endtask

  initial begin
    int l, r, t, b, tmp;

    reset                 = 1'b1;
    bus.TopandBottomFound = 1'b0;
    bus.leftFound         = 1'b0;
    bus.rightFound        = 1'b0;
    bus.mostLeft          = '0;
    bus.mostRight         = '0;
    bus.mostTop           = '0;
    bus.mostBottom        = '0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b0;
    tick();

    run_box("basic", 10, 14, 20, 23);

    model(5, 5, 30, 30);
    pulse(1'b1, 1'b0, 5, 0, 30, 30);
    repeat (6) tick();
    pulse(1'b0, 1'b1, 0, 5, 30, 30);
    collect(exp_addr.size() + 8, -1, 0);
    verify("point");

    run_box("badLR", 20, 10, 5, 8);
    run_box("badRange", 3, 60, 5, 8);

    pulse(1'b1, 1'b1, 0, 9, 0, 5);
    repeat (14) tick();
    check("abort pre_addr", int'(bus.address), 302);
    bus.TopandBottomFound = 1'b1;
    tick();
    bus.TopandBottomFound = 1'b0;
    check("abort wren", int'(bus.wren), 0);
    check("abort busy", int'(bus.busy), 0);
    check("abort boxDone", int'(bus.boxDone), 0);
    quiet("abort", 8);
    pulse(1'b1, 1'b0, 3, 0, 2, 4);
    quiet("abort flags", 6);
    model(3, 7, 2, 4);
    pulse(1'b0, 1'b1, 0, 7, 2, 4);
    collect(exp_addr.size() + 8, -1, 0);
    verify("after_abort");

    bus.TopandBottomFound = 1'b1;
    pulse(1'b1, 1'b1, 1, 2, 1, 2);
    bus.TopandBottomFound = 1'b0;
    quiet("abort priority", 8);

    model(2, 8, 1, 4);
    pulse(1'b1, 1'b1, 2, 8, 1, 4);
    collect(exp_addr.size() + 12, 4, 40);
    verify("busyR");

    pulse(1'b1, 1'b1, 0, 20, 10, 12);
    repeat (3) tick();
    check("midreset pre_wren", int'(bus.wren), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outputs_zero("midreset");
    quiet("midreset", 6);
    run_box("after_reset", 7, 9, 40, 59);

    for (int i = 0; i < 24; i++) begin
      l = int'($urandom_range(0, 63));
      r = int'($urandom_range(0, 63));
      t = int'($urandom_range(0, 63));
      b = int'($urandom_range(0, 63));
      if (i % 3 != 0) begin
        l = l % 60; r = r % 60; t = t % 60; b = b % 60;
        if (l > r) begin tmp = l; l = r; r = tmp; end
        if (t > b) begin tmp = t; t = b; b = tmp; end
      end
      run_box("random", l, r, t, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
